checksum_sequencer: RTL
=======================

Name: checksum_sequencer

Overview:
- Controller that owns the single port of the 16x8 data RAM.
- Arbitrates that port between the user-entry path (switch address/data, Enter, Prev/Next browsing) and an internal checksum engine.
- On a run request, sequences the engine through all RAM words and produces the 8-bit two's-complement checksum plus a busy-cycle count.
- Sits between the top-level UI state machine and ram; its results feed the seven-segment display path.

Parameters:
AW, 4, RAM address width; word count is 2**AW.
DW, 8, RAM data width and checksum width.
CW, 16, width of the busy-cycle counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
ui_req  input  1  UI requests the RAM port this cycle.
ui_we  input  1  UI write enable, qualified by ui_req.
ui_addr  input  AW  UI address.
ui_wdata  input  DW  UI write data.
ui_gnt  output  1  UI owns the port this cycle.
ui_rdata  output  DW  ram_dout passed through; valid one cycle after a granted read.
run  input  1  start request; level, sampled each cycle.
busy  output  1  engine owns the port.
done  output  1  one-cycle pulse when the checksum is valid.
checksum  output  DW  last computed checksum; held until the next run completes.
cycles  output  CW  busy-cycle count of the last run.
ram_we  output  1  to ram write enable.
ram_addr  output  AW  to ram address.
ram_din  output  DW  to ram write data.
ram_dout  input  DW  from ram; synchronous read, valid the cycle after the address.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, checksum=0, cycles=0, ui_gnt=0, ram_we=0, ram_addr=0, ram_din=0, internal sum and index = 0. No partial result survives reset.
- States: IDLE, PRIME, ACCUM, COMP, DONE.
- IDLE:
  - Port is combinationally steered to the UI: ram_addr=ui_addr, ram_din=ui_wdata, ram_we=ui_req&ui_we, ui_gnt=ui_req.
  - If run=1, the engine clears sum, index and cycles, and the next state is PRIME.
- Run and UI write in the same IDLE cycle: the write is performed. Because the engine's first read occurs later, the new data is included in the sum.
- PRIME (1 cycle): busy=1; ram_addr=0; ram_we=0; index<=1.
- ACCUM (exactly 2**AW cycles):
  - Each cycle: sum <= sum + ram_dout, modulo 2**DW with carries discarded.
  - ram_addr=index while index<2**AW; the address is held at the last word on the final cycle.
  - index increments each cycle.
  - After the cycle that adds word 2**AW-1, the next state is COMP.
- COMP (1 cycle): checksum <= (~sum)+1, truncated to DW bits. A sum of 0 therefore gives a checksum of 0.
- DONE (1 cycle): done=1, busy=0, then IDLE. The UI regains the port in the DONE cycle.
- cycles:
  - Increments every cycle busy=1 (PRIME, ACCUM, COMP) and saturates at 2**CW-1.
  - For AW=4 the final value is 18.
- Latency: run sampled at edge N; done is high during the cycle following edge N+18 (PRIME at N+1, ACCUM at N+2..N+17, COMP at N+18, DONE at N+19).
- While busy:
  - ui_gnt=0 and UI writes are dropped, not queued; the requester holds ui_req until granted.
  - run is ignored.
- run held high through DONE starts a new run on the first IDLE cycle after DONE. There is no automatic restart inside DONE.
- ram_we is never asserted by the engine.

Decomposition:
- Package checksum_pkg holds:
  - the state enum typedef;
  - default AW/DW/CW localparams;
  - N_WORDS=2**AW;
  - BUSY_CYCLES=N_WORDS+2.
- One sub-module, checksum_accum: clear, add-enable and data inputs; registered modulo sum and negated checksum output. The sequencer keeps the FSM, the port mux and the cycle counter.

Test Plan:
- Reset and idle: assert reset mid-simulation with no clock edge -> all outputs 0 immediately. ui_req=1, ui_we=1, ui_addr=3, ui_wdata=0xA5 -> ram_we=1, ram_addr=3, ui_gnt=1 in the same cycle.
- Incrementing data: write addr k = k+1 for k=0..15 (sum 0x88), pulse run -> busy for 18 cycles, done pulse at run edge +19, checksum=0x78, cycles=18.
- Wrap and zero cases: all words 0xFF -> checksum=0x10; all words 0x00 -> checksum=0x00.
- Contention: during ACCUM drive ui_req=1, ui_we=1, addr 5, data 0x00 -> ui_gnt=0, ram_we=0, word 5 unchanged after done, checksum matches the pre-run contents.
- Simultaneous run and write in IDLE: write addr 0=0x10 over 0x01 in the run cycle -> checksum reflects 0x10.
- Reset mid-ACCUM, then a second run pulse during busy: reset -> IDLE, checksum=0, no done. A fresh run then gives the correct value; the extra run while busy is ignored and produces exactly one done.

Source files
------------

// File: rtl/checksum_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : checksum_pkg
// Purpose  : Shared state encoding and default sizing for the checksum
//            sequencer and its accumulator.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package checksum_pkg;

   localparam int AW_DEF      = 4;
   localparam int DW_DEF      = 8;
   localparam int CW_DEF      = 16;
   localparam int N_WORDS     = 2**AW_DEF;
   localparam int BUSY_CYCLES = N_WORDS + 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRIME = 3'd1,
      ST_ACCUM = 3'd2,
      ST_COMP  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage : checksum_pkg
`default_nettype wire

// File: rtl/checksum_accum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : checksum_accum
// Purpose  : Modulo-2**DW running sum with a registered two's-complement
//            checksum captured on request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module checksum_accum import checksum_pkg::*; #(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear_i,
   input  logic          add_i,
   input  logic [DW-1:0] data_i,
   input  logic          load_i,
   output logic [DW-1:0] checksum_o
);

   localparam logic [DW-1:0] c_one = {{(DW-1){1'b0}}, 1'b1};

   logic [DW-1:0] sum_q, sum_d;
   logic [DW-1:0] checksum_q, checksum_d;

   // Next sum (clear wins over add) and checksum capture; carries fall off the top.
   always_comb begin
      sum_d      = sum_q;
      checksum_d = checksum_q;
      if (clear_i) begin
         sum_d = '0;
      end else if (add_i) begin
         sum_d = sum_q + data_i;
      end
      if (load_i) begin
         checksum_d = (~sum_q) + c_one;
      end
   end

   // Sum and checksum registers; checksum holds until the next capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q      <= '0;
         checksum_q <= '0;
      end else begin
         sum_q      <= sum_d;
         checksum_q <= checksum_d;
      end
   end

   assign checksum_o = checksum_q;

endmodule : checksum_accum
`default_nettype wire

// File: rtl/checksum_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : checksum_sequencer
// Purpose  : Owns the single RAM port, sharing it between the UI entry path
//            and a checksum engine that walks every word and reports the
//            two's-complement checksum and busy-cycle count.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module checksum_sequencer import checksum_pkg::*; #(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ui_req,
   input  logic          ui_we,
   input  logic [AW-1:0] ui_addr,
   input  logic [DW-1:0] ui_wdata,
   output logic          ui_gnt,
   output logic [DW-1:0] ui_rdata,
   input  logic          run,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] checksum,
   output logic [CW-1:0] cycles,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   // Index runs one past the last word so the final accumulate cycle is visible.
   localparam logic [AW:0]   c_n_words   = (AW+1)'(2**AW);
   localparam logic [AW:0]   c_idx_one   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] c_last_addr = '1;
   localparam logic [CW-1:0] c_cyc_one   = {{(CW-1){1'b0}}, 1'b1};

   state_e        state_q, state_d;
   logic [AW:0]   idx_q, idx_d;
   logic [CW-1:0] cycles_q, cycles_d;
   logic          acc_clear, acc_add, acc_load;

   // Saturating busy-cycle increment shared by all busy states.
   function automatic logic [CW-1:0] cyc_inc(input logic [CW-1:0] c);
      return (c == '1) ? c : c + c_cyc_one;
   endfunction

   // Next-state, port steering and engine control.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cycles_d  = cycles_q;
      acc_clear = 1'b0;
      acc_add   = 1'b0;
      acc_load  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      ui_gnt    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_din   = '0;
      case (state_q)
         ST_IDLE: begin
            ui_gnt   = ui_req;
            ram_we   = ui_req & ui_we;
            ram_addr = ui_addr;
            ram_din  = ui_wdata;
            if (run) begin
               acc_clear = 1'b1;
               idx_d     = '0;
               cycles_d  = '0;
               state_d   = ST_PRIME;
            end
         end
         ST_PRIME: begin
            busy     = 1'b1;
            ram_addr = '0;
            idx_d    = c_idx_one;
            cycles_d = cyc_inc(cycles_q);
            state_d  = ST_ACCUM;
         end
         ST_ACCUM: begin
            busy     = 1'b1;
            acc_add  = 1'b1;
            ram_addr = (idx_q < c_n_words) ? idx_q[AW-1:0] : c_last_addr;
            idx_d    = idx_q + c_idx_one;
            cycles_d = cyc_inc(cycles_q);
            if (idx_q == c_n_words) begin
               state_d = ST_COMP;
            end
         end
         ST_COMP: begin
            busy     = 1'b1;
            acc_load = 1'b1;
            cycles_d = cyc_inc(cycles_q);
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            done     = 1'b1;
            ui_gnt   = ui_req;
            ram_we   = ui_req & ui_we;
            ram_addr = ui_addr;
            ram_din  = ui_wdata;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, word index and cycle counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cycles_q <= cycles_d;
      end
   end

   checksum_accum #(
      .DW (DW)
   ) u_accum (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (acc_clear),
      .add_i      (acc_add),
      .data_i     (ram_dout),
      .load_i     (acc_load),
      .checksum_o (checksum)
   );

   assign cycles   = cycles_q;
   assign ui_rdata = ram_dout;

endmodule : checksum_sequencer
`default_nettype wire
